gin_bus: RTL and testbench

Global-input-network multicast bus: the delivery counterpart of the output gather network. It takes one tagged word per transaction from the GLB or an upstream bus and delivers it to every downstream PE or row whose scanned-in ID equals the tag. A transaction completes only when every matching target has taken the word. Y-level and X-level instances chain their ID scan paths, so a GIN is one Y bus feeding `NUMS_PE_ROW` X buses.

---
 rtl/gin_bus.sv | 103 ++++++++++
 tb/tb_gin_bus.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_bus.sv
// gin_bus: tagged multicast delivery bus for the global input network.
// Each word goes to every target whose scanned-in ID equals its tag.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module gin_bus #(
  parameter int NUMS_SLAVE = 8,
  parameter int ID_BITS    = 4,
  parameter int DATA_BITS  = `DATA_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ID_BITS-1:0]              tag,
  input  logic                            master_valid,
  output logic                            master_ready,
  input  logic [DATA_BITS-1:0]            master_data,
  output logic [NUMS_SLAVE-1:0]           slave_valid,
  input  logic [NUMS_SLAVE-1:0]           slave_ready,
  output logic [DATA_BITS*NUMS_SLAVE-1:0] slave_data,
  input  logic                            set_id,
  input  logic [ID_BITS-1:0]              ID_scan_in,
  output logic [ID_BITS-1:0]              ID_scan_out,
  output logic                            miss
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state;
  logic [ID_BITS-1:0]    id [NUMS_SLAVE];
  logic [NUMS_SLAVE-1:0] pending;
  logic [NUMS_SLAVE-1:0] match;
  logic [DATA_BITS-1:0]  data_q;
  logic                  last;
  logic                  accept;

  // Tag compare against the IDs as they stand before any shift this cycle
  always_comb begin
    match = '0;
    for (int k = 0; k < NUMS_SLAVE; k++) begin
      match[k] = (id[k] == tag);
    end
  end

  // Word is finished once every still-pending target handshakes now
  always_comb begin
    last = 1'b1;
    if (state == SEND) begin
      last = ((pending & ~slave_ready) == '0);
    end
  end

  assign master_ready = last;
  assign accept       = master_valid & last;
  assign slave_valid  = pending;
  assign slave_data   = {NUMS_SLAVE{data_q}};
  assign ID_scan_out  = id[NUMS_SLAVE-1];

  // ID scan chain, independent of the data path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUMS_SLAVE; k++) begin
        id[k] <= '0;
      end
    end else if (set_id) begin
      id[0] <= ID_scan_in;
      for (int k = 1; k < NUMS_SLAVE; k++) begin
        id[k] <= id[k-1];
      end
    end
  end

  // Delivery FSM: latch word and mask, retire targets as they handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= '0;
      data_q  <= '0;
      miss    <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (accept) begin
        data_q  <= master_data;
        pending <= match;
        if (match != '0) begin
          state <= SEND;
        end else begin
          state <= IDLE;
          miss  <= 1'b1;
        end
      end else if (state == SEND) begin
        pending <= pending & ~slave_ready;
        if (last) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_gin_bus.sv
// tb_gin_bus: scoreboard bench for gin_bus.
// Stimulus pushes expected deliveries; a monitor retires them.
module tb_gin_bus;

  logic          clk;
  logic          rst;
  logic [3:0]    tag;
  logic          master_valid;
  logic          master_ready;
  logic [31:0]   master_data;
  logic [7:0]    slave_valid;
  logic [7:0]    slave_ready;
  logic [255:0]  slave_data;
  logic          set_id;
  logic [3:0]    ID_scan_in;
  logic [3:0]    ID_scan_out;
  logic          miss;

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] delivered;
  int         n_chk;
  int         n_fail;
  int         w;

  gin_bus #(
    .NUMS_SLAVE(8),
    .ID_BITS(4),
    .DATA_BITS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tag(tag),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .master_data(master_data),
    .slave_valid(slave_valid),
    .slave_ready(slave_ready),
    .slave_data(slave_data),
    .set_id(set_id),
    .ID_scan_in(ID_scan_in),
    .ID_scan_out(ID_scan_out),
    .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ids(input logic [31:0] ids);
    for (int i = 7; i >= 0; i--) begin
      ID_scan_in = ids[i*4+:4];
      set_id = 1'b1;
      step();
    end
    set_id = 1'b0;
    chk("scan_out_after_load", 64'(ID_scan_out), 64'(ids[31:28]));
  endtask

  task automatic send(input logic [3:0] t, input logic [31:0] d,
                      input logic [7:0] m, output int waits);
    tag = t;
    master_data = d;
    master_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!master_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!master_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end else begin
      q.push_back('{mask: m, data: d});
    end
    step();
    master_valid = 1'b0;
  endtask

  // Monitor: retire each expected word as its targets handshake
  always @(negedge clk) begin
    if (!rst) begin
      delivered = '0;
    end else begin
      if (miss) begin
        n_chk++;
        if (q.size() == 0 || q[0].mask != 8'h00) begin
          n_fail++;
          $display("FAIL miss_pulse: got miss=1 expected no miss");
        end else begin
          void'(q.pop_front());
        end
      end
      if (slave_valid != 8'h00) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_valid: got %0h expected 0", slave_valid);
        end else begin
          chk("valid_mask", 64'(slave_valid & ~(q[0].mask & ~delivered)),
              64'h0);
          for (int k = 0; k < 8; k++) begin
            if (slave_valid[k] && slave_ready[k]) begin
              chk($sformatf("data_s%0d", k), 64'(slave_data[k*32+:32]),
                  64'(q[0].data));
              delivered[k] = 1'b1;
            end
          end
          if (delivered == q[0].mask) begin
            void'(q.pop_front());
            delivered = '0;
          end
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    delivered = '0;
    tag = '0;
    master_valid = 1'b0;
    master_data = '0;
    slave_ready = 8'hFF;
    set_id = 1'b0;
    ID_scan_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_master_ready", 64'(master_ready), 64'h1);
    chk("rst_slave_valid", 64'(slave_valid), 64'h0);
    chk("rst_slave_data", 64'(slave_data[63:0]), 64'h0);
    chk("rst_scan_out", 64'(ID_scan_out), 64'h0);
    chk("rst_miss", 64'(miss), 64'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // scan load id[k]=k, then one more shift of F
    load_ids(32'h7654_3210);
    ID_scan_in = 4'hF;
    set_id = 1'b1;
    @(negedge clk);
    chk("scan_before_9th", 64'(ID_scan_out), 64'h7);
    step();
    set_id = 1'b0;
    chk("scan_after_9th", 64'(ID_scan_out), 64'h6);
    send(4'hF, 32'hDEAD_0009, 8'h01, w);
    send(4'h0, 32'hDEAD_000A, 8'h02, w);

    // unicast
    load_ids(32'h7654_3210);
    send(4'h3, 32'hA5A5_0001, 8'h08, w);
    @(negedge clk);
    chk("uni_valid", 64'(slave_valid), 64'h08);
    chk("uni_ready", 64'(master_ready), 64'h1);
    step();
    @(negedge clk);
    chk("uni_idle_valid", 64'(slave_valid), 64'h00);

    // miss
    step();
    send(4'hF, 32'h0000_BEEF, 8'h00, w);
    @(negedge clk);
    chk("miss_valid", 64'(slave_valid), 64'h00);
    chk("miss_ready", 64'(master_ready), 64'h1);
    chk("miss_high", 64'(miss), 64'h1);
    step();
    @(negedge clk);
    chk("miss_cleared", 64'(miss), 64'h0);

    // back-to-back alternating tags, all targets ready
    step();
    send(4'h3, 32'h1111_0003, 8'h08, w);
    chk("b2b_wait0", 64'(w), 64'h0);
    send(4'h5, 32'h2222_0005, 8'h20, w);
    chk("b2b_wait1", 64'(w), 64'h0);
    send(4'h3, 32'h3333_0003, 8'h08, w);
    chk("b2b_wait2", 64'(w), 64'h0);
    send(4'h5, 32'h4444_0005, 8'h20, w);
    chk("b2b_wait3", 64'(w), 64'h0);
    @(negedge clk);
    chk("b2b_last_valid", 64'(slave_valid), 64'h20);
    step();

    // multicast with staggered ready
    load_ids(32'h1112_1112);
    slave_ready = 8'h00;
    send(4'h2, 32'hC0DE_0002, 8'h11, w);
    slave_ready = 8'h10;
    @(negedge clk);
    chk("mc_c1_valid", 64'(slave_valid), 64'h11);
    chk("mc_c1_ready", 64'(master_ready), 64'h0);
    step();
    slave_ready = 8'h00;
    @(negedge clk);
    chk("mc_c2_valid", 64'(slave_valid), 64'h01);
    chk("mc_c2_ready", 64'(master_ready), 64'h0);
    step();
    slave_ready = 8'h01;
    @(negedge clk);
    chk("mc_c3_ready", 64'(master_ready), 64'h1);
    step();
    slave_ready = 8'hFF;
    @(negedge clk);
    chk("mc_done_valid", 64'(slave_valid), 64'h00);

    // reset while a multicast is pending
    step();
    slave_ready = 8'h00;
    send(4'h2, 32'hFACE_0002, 8'h11, w);
    @(negedge clk);
    chk("rs_pending", 64'(slave_valid), 64'h11);
    #2 rst = 1'b0;
    #1;
    chk("rs_valid_cleared", 64'(slave_valid), 64'h00);
    q.delete();
    step();
    rst = 1'b1;
    slave_ready = 8'hFF;
    #1;
    chk("rs_master_ready", 64'(master_ready), 64'h1);
    chk("rs_scan_out", 64'(ID_scan_out), 64'h0);
    step();
    send(4'h0, 32'h0000_00FF, 8'hFF, w);

    repeat (4) step();
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
